// File: rtl/pipe_ex_mem_skid.sv
// EX/MEM pipeline boundary with valid/ready handshake, optional one-entry skid
// buffer, synchronous flush, bubble defaults, sticky halt and a stall counter.
module pipe_ex_mem_skid #(
   parameter int BITS      = 32,
   parameter int REG_WORDS = 32,
   parameter int ADDR_LEFT = $clog2(REG_WORDS) - 1,
   parameter int BE_BITS   = BITS / 8,
   parameter int SKID      = 1,
   parameter int CNT_BITS  = 16
) (
   input  logic                clk,
   input  logic                rst_,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [BITS-1:0]     alu_out_s3,
   input  logic [BITS-1:0]     r2_data_s3,
   input  logic [ADDR_LEFT:0]  waddr_s3,
   input  logic [BE_BITS-1:0]  byte_en_s3,
   input  logic                atomic_s3,
   input  logic                sel_mem_s3,
   input  logic                check_link_s3,
   input  logic                mem_rw_s3,
   input  logic                rw_s3,
   input  logic                load_link_s3,
   input  logic                halt_s3,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [BITS-1:0]     alu_out_s4,
   output logic [BITS-1:0]     r2_data_s4,
   output logic [ADDR_LEFT:0]  waddr_s4,
   output logic [BE_BITS-1:0]  byte_en_s4,
   output logic                atomic_s4,
   output logic                sel_mem_s4,
   output logic                check_link_s4,
   output logic                mem_rw_s4,
   output logic                rw_s4,
   output logic                load_link_s4,
   output logic                halt_s4,
   output logic                halted,
   input  logic                stall_clr,
   output logic [CNT_BITS-1:0] stall_cnt
);

   typedef struct packed {
      logic [BITS-1:0]    alu_out;
      logic [BITS-1:0]    r2_data;
      logic [ADDR_LEFT:0] waddr;
      logic [BE_BITS-1:0] byte_en;
      logic               atomic;
      logic               sel_mem;
      logic               check_link;
      logic               mem_rw;
      logic               rw;
      logic               load_link;
      logic               halt;
   } entry_t;

   // rw/mem_rw/load_link high and full byte enables encode "no write" downstream.
   localparam entry_t BUBBLE = '{alu_out: '0, r2_data: '0, waddr: '0, byte_en: '1,
                                 atomic: 1'b0, sel_mem: 1'b0, check_link: 1'b0,
                                 mem_rw: 1'b1, rw: 1'b1, load_link: 1'b1, halt: 1'b0};

   entry_t in_entry, main_q, main_n, skid_q, skid_n;
   logic   main_valid, main_valid_n, skid_valid, skid_valid_n;
   logic   accept, consume;

   assign in_entry = '{alu_out: alu_out_s3, r2_data: r2_data_s3, waddr: waddr_s3,
                       byte_en: byte_en_s3, atomic: atomic_s3, sel_mem: sel_mem_s3,
                       check_link: check_link_s3, mem_rw: mem_rw_s3, rw: rw_s3,
                       load_link: load_link_s3, halt: halt_s3};

   // Valid/ready: a transfer happens on a rising edge where valid and ready are
   // both high; valid never depends on ready, and payload is held while valid waits.
   assign accept  = in_valid & in_ready;
   assign consume = main_valid & out_ready;

   generate
      if (SKID != 0) begin : g_skid_ready
         assign in_ready = ~skid_valid & ~halted & ~rst_;
      end else begin : g_direct_ready
         assign in_ready = (~main_valid | out_ready) & ~halted & ~rst_;
      end
   endgenerate

   always_comb begin
      main_valid_n = main_valid;
      main_n       = main_q;
      skid_valid_n = skid_valid;
      skid_n       = skid_q;
      if (flush) begin
         main_valid_n = 1'b0;
         main_n       = BUBBLE;
         skid_valid_n = 1'b0;
         skid_n       = BUBBLE;
      end else if (consume) begin
         if (skid_valid) begin
            main_n       = skid_q;
            skid_valid_n = 1'b0;
            skid_n       = BUBBLE;
         end else if (accept) begin
            main_n = in_entry;
         end else begin
            main_valid_n = 1'b0;
            main_n       = BUBBLE;
         end
      end else if (accept) begin
         if (!main_valid) begin
            main_valid_n = 1'b1;
            main_n       = in_entry;
         end else if (SKID != 0) begin
            skid_valid_n = 1'b1;
            skid_n       = in_entry;
         end
      end
   end

   always_ff @(posedge clk or posedge rst_) begin
      if (rst_) begin
         main_valid <= 1'b0;
         main_q     <= BUBBLE;
         skid_valid <= 1'b0;
         skid_q     <= BUBBLE;
         halted     <= 1'b0;
         stall_cnt  <= '0;
      end else begin
         main_valid <= main_valid_n;
         main_q     <= main_n;
         skid_valid <= skid_valid_n;
         skid_q     <= skid_n;
         if (consume && main_q.halt) halted <= 1'b1;
         if (stall_clr) stall_cnt <= '0;
         else if (main_valid && !out_ready && stall_cnt != '1)
            stall_cnt <= stall_cnt + CNT_BITS'(1);
      end
   end

   assign out_valid     = main_valid;
   assign alu_out_s4    = main_q.alu_out;
   assign r2_data_s4    = main_q.r2_data;
   assign waddr_s4      = main_q.waddr;
   assign byte_en_s4    = main_q.byte_en;
   assign atomic_s4     = main_q.atomic;
   assign sel_mem_s4    = main_q.sel_mem;
   assign check_link_s4 = main_q.check_link;
   assign mem_rw_s4     = main_q.mem_rw;
   assign rw_s4         = main_q.rw;
   assign load_link_s4  = main_q.load_link;
   assign halt_s4       = main_q.halt;

endmodule

// File: tb/tb_pipe_ex_mem_skid.sv
// Drives a SKID=1 and a SKID=0 instance with shared stimulus and checks both
// against a FIFO-occupancy reference model.
module tb_pipe_ex_mem_skid;

   typedef struct packed {
      logic [31:0] alu;
      logic [31:0] r2;
      logic [4:0]  waddr;
      logic [3:0]  be;
      logic        atomic;
      logic        sel_mem;
      logic        check_link;
      logic        mem_rw;
      logic        rw;
      logic        load_link;
      logic        halt;
   } ent_t;

   localparam ent_t BUB = '{alu: 32'h0, r2: 32'h0, waddr: 5'h0, be: 4'hf,
                            atomic: 1'b0, sel_mem: 1'b0, check_link: 1'b0,
                            mem_rw: 1'b1, rw: 1'b1, load_link: 1'b1, halt: 1'b0};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, flush, in_valid, out_ready, stall_clr;
   ent_t din;
   logic [1:0] ov, ir, hl;
   logic [3:0] sc0, sc1;
   ent_t p0, p1;

   pipe_ex_mem_skid #(.SKID(1), .CNT_BITS(4)) dut_s1 (
      .clk(clk), .rst_(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
      .alu_out_s3(din.alu), .r2_data_s3(din.r2), .waddr_s3(din.waddr), .byte_en_s3(din.be),
      .atomic_s3(din.atomic), .sel_mem_s3(din.sel_mem), .check_link_s3(din.check_link),
      .mem_rw_s3(din.mem_rw), .rw_s3(din.rw), .load_link_s3(din.load_link), .halt_s3(din.halt),
      .out_valid(ov[1]), .out_ready(out_ready),
      .alu_out_s4(p1.alu), .r2_data_s4(p1.r2), .waddr_s4(p1.waddr), .byte_en_s4(p1.be),
      .atomic_s4(p1.atomic), .sel_mem_s4(p1.sel_mem), .check_link_s4(p1.check_link),
      .mem_rw_s4(p1.mem_rw), .rw_s4(p1.rw), .load_link_s4(p1.load_link), .halt_s4(p1.halt),
      .halted(hl[1]), .stall_clr(stall_clr), .stall_cnt(sc1));

   pipe_ex_mem_skid #(.SKID(0), .CNT_BITS(4)) dut_s0 (
      .clk(clk), .rst_(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
      .alu_out_s3(din.alu), .r2_data_s3(din.r2), .waddr_s3(din.waddr), .byte_en_s3(din.be),
      .atomic_s3(din.atomic), .sel_mem_s3(din.sel_mem), .check_link_s3(din.check_link),
      .mem_rw_s3(din.mem_rw), .rw_s3(din.rw), .load_link_s3(din.load_link), .halt_s3(din.halt),
      .out_valid(ov[0]), .out_ready(out_ready),
      .alu_out_s4(p0.alu), .r2_data_s4(p0.r2), .waddr_s4(p0.waddr), .byte_en_s4(p0.be),
      .atomic_s4(p0.atomic), .sel_mem_s4(p0.sel_mem), .check_link_s4(p0.check_link),
      .mem_rw_s4(p0.mem_rw), .rw_s4(p0.rw), .load_link_s4(p0.load_link), .halt_s4(p0.halt),
      .halted(hl[0]), .stall_clr(stall_clr), .stall_cnt(sc0));

   // Reference model: index 1 is the two-deep instance, index 0 the one-deep one.
   ent_t       mq[2][2];
   int         mcnt[2];
   logic       mhalt[2];
   logic [3:0] mst[2];
   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic m_ready(input int k);
      if (rst || mhalt[k]) return 1'b0;
      if (k == 1) return mcnt[k] < 2;
      return (mcnt[k] == 0) || out_ready;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         mcnt[k] = 0; mhalt[k] = 1'b0; mst[k] = 4'd0;
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < 2; k++) begin
         ent_t e;
         e = (mcnt[k] > 0) ? mq[k][0] : BUB;
         check($sformatf("out_valid[%0d]", k), 96'(ov[k]), 96'(mcnt[k] > 0));
         check($sformatf("payload[%0d]", k), 96'((k == 1) ? p1 : p0), 96'(e));
         check($sformatf("in_ready[%0d]", k), 96'(ir[k]), 96'(m_ready(k)));
         check($sformatf("halted[%0d]", k), 96'(hl[k]), 96'(mhalt[k]));
         check($sformatf("stall_cnt[%0d]", k), 96'((k == 1) ? sc1 : sc0), 96'(mst[k]));
      end
   endtask

   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         logic acc, con, hv;
         acc = in_valid && m_ready(k);
         con = (mcnt[k] > 0) && out_ready;
         hv  = (mcnt[k] > 0) && mq[k][0].halt;
         if (stall_clr) mst[k] = 4'd0;
         else if (mcnt[k] > 0 && !out_ready && mst[k] != 4'd15) mst[k] = mst[k] + 4'd1;
         if (flush) mcnt[k] = 0;
         else begin
            if (con) begin mq[k][0] = mq[k][1]; mcnt[k]--; end
            if (acc) begin mq[k][mcnt[k]] = din; mcnt[k]++; end
         end
         if (con && hv) mhalt[k] = 1'b1;
      end
   endtask

   // Called at edge+1; checks mid-cycle, then advances the model across the edge.
   task automatic cycle();
      #2;
      if (rst) model_reset();
      check_all();
      @(posedge clk);
      #1;
      if (rst) model_reset();
      else model_step();
   endtask

   task automatic put(input logic v, input logic [31:0] a, input logic h);
      in_valid = v;
      din = '{alu: a, r2: a ^ 32'h5555_aaaa, waddr: a[4:0], be: 4'h3, atomic: 1'b0,
              sel_mem: 1'b1, check_link: 1'b0, mem_rw: 1'b0, rw: 1'b1,
              load_link: 1'b0, halt: h};
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; stall_clr = 1'b0;
      din = BUB;
      model_reset();
      #1;
      cycle(); cycle();
      rst = 1'b0;

      // stream with no backpressure
      out_ready = 1'b1;
      put(1, 32'h10, 0); cycle();
      put(1, 32'h11, 0); cycle();
      put(1, 32'h12, 0); cycle();
      put(0, 32'h0, 0); cycle(); cycle();
      check("stream_ready", 96'(ir[1]), 96'(1));

      // backpressure fills main then skid
      out_ready = 1'b0;
      put(1, 32'ha, 0); cycle();
      put(1, 32'hb, 0); cycle();
      put(0, 32'h0, 0); cycle(); cycle();
      check("skid_full_ready", 96'(ir[1]), 96'(0));
      check("bp_stall", 96'(sc1), 96'(3));
      out_ready = 1'b1;
      cycle(); cycle(); cycle();

      // flush with both entries held and a same-cycle offer
      out_ready = 1'b0;
      put(1, 32'ha1, 0); cycle();
      put(1, 32'hb1, 0); cycle();
      flush = 1'b1; put(1, 32'hc1, 0); cycle();
      flush = 1'b0; put(0, 32'h0, 0);
      check("flush_valid", 96'(ov[1]), 96'(0));
      check("flush_bubble", 96'(p1), 96'(BUB));
      out_ready = 1'b1;
      cycle(); cycle();

      // counter saturation and clear priority
      stall_clr = 1'b1; cycle(); stall_clr = 1'b0;
      out_ready = 1'b0;
      put(1, 32'h77, 0); cycle();
      put(0, 32'h0, 0);
      for (int i = 0; i < 20; i++) cycle();
      check("stall_sat", 96'(sc1), 96'(15));
      stall_clr = 1'b1; cycle(); stall_clr = 1'b0;
      check("stall_clr", 96'(sc1), 96'(0));
      out_ready = 1'b1; cycle(); cycle();

      // halt then later entries
      put(1, 32'h40, 1); cycle();
      put(1, 32'hd, 0); cycle();
      put(1, 32'he, 0); cycle(); cycle(); cycle();
      check("halt_set", 96'(hl[1]), 96'(1));
      check("halt_ready", 96'(ir[1]), 96'(0));
      put(0, 32'h0, 0);
      rst = 1'b1; cycle(); rst = 1'b0;
      check("halt_reset", 96'(hl[1]), 96'(0));

      // async reset between edges with buffers full
      out_ready = 1'b0;
      put(1, 32'h91, 0); cycle();
      put(1, 32'h92, 0); cycle();
      put(0, 32'h0, 0);
      #3; rst = 1'b1; #1;
      check("async_valid1", 96'(ov[1]), 96'(0));
      check("async_bubble1", 96'(p1), 96'(BUB));
      check("async_valid0", 96'(ov[0]), 96'(0));
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      cycle();

      // one-deep instance: in_ready tracks out_ready within the cycle
      put(1, 32'h55, 0); cycle();
      put(0, 32'h0, 0); cycle();
      out_ready = 1'b1; cycle();
      out_ready = 1'b0; put(1, 32'h56, 0); cycle(); cycle();
      out_ready = 1'b1; cycle(); put(0, 32'h0, 0); cycle();

      // randomized traffic
      for (int i = 0; i < 500; i++) begin
         rst       = ($urandom_range(0, 39) == 0);
         flush     = ($urandom_range(0, 11) == 0);
         stall_clr = ($urandom_range(0, 19) == 0);
         out_ready = ($urandom_range(0, 2) != 0);
         put($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 24) == 0);
         din.r2 = $urandom;
         din.be = 4'($urandom);
         {din.atomic, din.sel_mem, din.check_link, din.mem_rw, din.rw, din.load_link} = 6'($urandom);
         cycle();
      end
      rst = 1'b0; flush = 1'b0; stall_clr = 1'b0;
      put(0, 32'h0, 0);
      cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
